// File: rtl/fp_vector_checker_pkg.sv
// Shared state encoding and default parameter values for the FP vector checker.
package fp_vector_checker_pkg;

  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefDepth = 22;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefCntW  = 8;
  localparam int unsigned DefTmoW  = 10;
  localparam int unsigned DefKeyW  = 64;

  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StFetch = 6'b000010,
    StLoad  = 6'b000100,
    StCall  = 6'b001000,
    StWait  = 6'b010000,
    StCheck = 6'b100000
  } state_e;

endpackage

// File: rtl/fp_mismatch_tracker.sv
// Result compare, saturating mismatch counter and first-failure index capture.
module fp_mismatch_tracker #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              check,
  input  logic              force_fail,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] expected,
  input  logic [ADDR_W-1:0] idx,
  output logic              mismatch,
  output logic [CNT_W-1:0]  count,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] first_fail_idx
);

  logic [CNT_W-1:0]  count_q;
  logic              fail_valid_q;
  logic [ADDR_W-1:0] first_q;

  assign mismatch = check && (force_fail || (result != expected));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      fail_valid_q <= 1'b0;
      first_q      <= '0;
    end else if (clear) begin
      count_q      <= '0;
      fail_valid_q <= 1'b0;
      first_q      <= '0;
    end else if (mismatch) begin
      if (count_q != {CNT_W{1'b1}}) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (!fail_valid_q) begin
        fail_valid_q <= 1'b1;
        first_q      <= idx;
      end
    end
  end

  assign count          = count_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_idx = first_q;

endmodule

// File: rtl/fp_vector_checker.sv
// Walks a table of subtract test vectors through an external core and counts mismatches.
module fp_vector_checker
  import fp_vector_checker_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned TMO_W  = DefTmoW,
  parameter int unsigned KEY_W  = DefKeyW
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic              stop_on_fail,
  output logic              vec_ce,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [DATA_W-1:0] vec_a,
  input  logic [DATA_W-1:0] vec_b,
  input  logic [DATA_W-1:0] vec_z,
  output logic              core_start,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  output logic              core_zsign,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [CNT_W-1:0]  ap_return,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              timeout_flag,
  input  logic [KEY_W-1:0]  working_key
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, vec_addr_q;
  logic [DATA_W-1:0] a_q, b_q, z_q, res_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              load_ph_q, stop_q, abort_q, skip_q, zsign_q;
  logic              vec_ce_q, core_start_q, tmo_flag_q, tmo_hit_q;
  logic              run_end, sign_diff, tmo_max, start_run, mismatch;
  logic              unused_key;

  assign run_end    = (idx_q == ADDR_W'(DEPTH)) || abort_q;
  assign sign_diff  = vec_a[DATA_W-1] ^ vec_b[DATA_W-1];
  assign tmo_max    = (tmo_q == {TMO_W{1'b1}});
  assign start_run  = (state_q == StIdle) && ap_start;
  assign unused_key = ^working_key[KEY_W-1:4];

  always_comb begin
    state_d  = state_q;
    ap_done  = 1'b0;
    ap_ready = 1'b0;
    ap_idle  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ap_idle = !ap_start;
        if (ap_start) state_d = working_key[0] ? StLoad : StFetch;
      end
      StFetch: begin
        if (run_end) begin
          ap_done  = 1'b1;
          ap_ready = 1'b1;
          state_d  = StIdle;
        end else begin
          state_d = working_key[1] ? StCheck : StLoad;
        end
      end
      StLoad: begin
        if (load_ph_q) begin
          if (sign_diff) state_d = StCall;
          else           state_d = working_key[2] ? StFetch : StCheck;
        end
      end
      StCall: state_d = StWait;
      StWait: begin
        if (core_done)    state_d = working_key[3] ? StFetch : StCheck;
        else if (tmo_max) state_d = StCheck;
      end
      StCheck: state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  // LOAD spends one cycle issuing the read and one capturing the returned vector.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      vec_addr_q   <= '0;
      a_q          <= '0;
      b_q          <= '0;
      z_q          <= '0;
      res_q        <= '0;
      tmo_q        <= '0;
      load_ph_q    <= 1'b0;
      stop_q       <= 1'b0;
      abort_q      <= 1'b0;
      skip_q       <= 1'b0;
      zsign_q      <= 1'b0;
      vec_ce_q     <= 1'b0;
      core_start_q <= 1'b0;
      tmo_flag_q   <= 1'b0;
      tmo_hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_ce_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ap_start) begin
            idx_q      <= '0;
            stop_q     <= stop_on_fail;
            abort_q    <= 1'b0;
            tmo_flag_q <= 1'b0;
            load_ph_q  <= 1'b0;
          end
        end
        StFetch: begin
          if (!run_end) begin
            vec_ce_q   <= 1'b1;
            vec_addr_q <= idx_q;
          end
        end
        StLoad: begin
          if (!load_ph_q) begin
            load_ph_q <= 1'b1;
          end else begin
            load_ph_q    <= 1'b0;
            a_q          <= vec_a;
            b_q          <= vec_b;
            z_q          <= vec_z;
            zsign_q      <= vec_a[DATA_W-1];
            skip_q       <= !sign_diff;
            core_start_q <= sign_diff;
          end
        end
        StCall: begin
          tmo_q     <= '0;
          tmo_hit_q <= 1'b0;
        end
        StWait: begin
          if (core_done) begin
            res_q        <= core_result;
            core_start_q <= 1'b0;
          end else if (tmo_max) begin
            tmo_flag_q   <= 1'b1;
            tmo_hit_q    <= 1'b1;
            core_start_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        StCheck: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (stop_q && mismatch) abort_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  fp_mismatch_tracker #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_tracker (
    .clk           (ap_clk),
    .rst_n         (ap_rst_n),
    .clear         (start_run),
    .check         ((state_q == StCheck) && !skip_q),
    .force_fail    (tmo_hit_q),
    .result        (res_q),
    .expected      (z_q),
    .idx           (idx_q),
    .mismatch      (mismatch),
    .count         (ap_return),
    .fail_valid    (fail_valid),
    .first_fail_idx(first_fail_idx)
  );

  assign vec_ce       = vec_ce_q;
  assign vec_addr     = vec_addr_q;
  assign core_start   = core_start_q;
  assign core_a       = a_q;
  assign core_b       = b_q;
  assign core_zsign   = zsign_q;
  assign timeout_flag = tmo_flag_q;

endmodule

// File: tb/tb_fp_vector_checker.sv
// Directed, table-driven bench: vector ROM and a 3-cycle subtract-core stand-in around the DUT.
module tb_fp_vector_checker;

  localparam int Depth = 22;

  logic        ap_clk, ap_rst_n, ap_start, ap_done, ap_idle, ap_ready, stop_on_fail;
  logic        vec_ce, core_start, core_zsign, core_done, fail_valid, timeout_flag;
  logic [4:0]  vec_addr, first_fail_idx;
  logic [63:0] vec_a, vec_b, vec_z, core_a, core_b, core_result, working_key;
  logic [7:0]  ap_return;

  logic [63:0] mem_a [32];
  logic [63:0] mem_b [32];
  logic [63:0] mem_z [32];
  logic [31:0] corrupt_mask;
  int          hang_idx;
  logic        c_busy;
  int          c_cnt;
  int          checks, errors;

  fp_vector_checker dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .stop_on_fail  (stop_on_fail),
    .vec_ce        (vec_ce),
    .vec_addr      (vec_addr),
    .vec_a         (vec_a),
    .vec_b         (vec_b),
    .vec_z         (vec_z),
    .core_start    (core_start),
    .core_a        (core_a),
    .core_b        (core_b),
    .core_zsign    (core_zsign),
    .core_done     (core_done),
    .core_result   (core_result),
    .ap_return     (ap_return),
    .fail_valid    (fail_valid),
    .first_fail_idx(first_fail_idx),
    .timeout_flag  (timeout_flag),
    .working_key   (working_key)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) begin
    if (vec_ce) begin
      vec_a <= mem_a[vec_addr];
      vec_b <= mem_b[vec_addr];
      vec_z <= mem_z[vec_addr];
    end
  end

  // Core stand-in: result = a ^ b (optionally corrupted), done 3 cycles after start is seen.
  always @(posedge ap_clk) begin
    if (!core_start) begin
      c_busy    <= 1'b0;
      c_cnt     <= 0;
      core_done <= 1'b0;
    end else if (core_done) begin
      core_done <= 1'b0;
    end else if (!c_busy) begin
      c_busy <= 1'b1;
      c_cnt  <= 1;
    end else if (c_cnt == 2) begin
      if (int'(core_a[7:0]) != hang_idx) begin
        core_done   <= 1'b1;
        core_result <= core_a ^ core_b ^ {63'd0, corrupt_mask[core_a[4:0]]};
      end
    end else begin
      c_cnt <= c_cnt + 1;
    end
  end

  typedef struct {
    string       name;
    logic [3:0]  key;
    logic        stop;
    logic        same_sign;
    logic [31:0] corrupt;
    int          hang;
    int          exp_ret;
    int          exp_fv;
    int          exp_first;
    int          exp_tmo;
    int          exp_cycles;
    int          exp_cs;
  } scen_t;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic setup(input scen_t s);
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = {~s.same_sign, 55'(i * 12345 + 7), 8'(i)};
      mem_b[i] = {1'b0, 55'(i * 777 + 3), 8'(i + 100)};
      mem_z[i] = mem_a[i] ^ mem_b[i];
    end
    corrupt_mask = s.corrupt;
    hang_idx     = s.hang;
    stop_on_fail = s.stop;
    working_key  = 64'hDEAD_BEEF_0000_0000 | 64'(s.key);
  endtask

  task automatic run(output int cycles, output int cs);
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    cycles = 0;
    cs     = 0;
    while (!ap_done && cycles < 4000) begin
      @(posedge ap_clk);
      #1;
      cycles++;
      if (core_start) cs++;
    end
  endtask

  scen_t tbl[5];
  int    n, cs;
  logic [7:0] held;

  initial begin
    checks = 0;
    errors = 0;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    stop_on_fail = 1'b0;
    working_key = '0;
    corrupt_mask = '0;
    hang_idx = -1;

    tbl[0] = '{"all_differ",  4'h0, 1'b0, 1'b0, 32'h0,   -1, 0, 1'b0, 0, 1'b0, 176,  88};
    tbl[1] = '{"corrupt_5_9", 4'h0, 1'b0, 1'b0, 32'h220, -1, 2, 1'b1, 5, 1'b0, 176,  88};
    tbl[2] = '{"stop_on_5",   4'h0, 1'b1, 1'b0, 32'h220, -1, 1, 1'b1, 5, 1'b0, 48,   24};
    tbl[3] = '{"hang_3",      4'h0, 1'b0, 1'b0, 32'h0,    3, 1, 1'b1, 3, 1'b1, 1197, 1109};
    tbl[4] = '{"all_equal",   4'h0, 1'b0, 1'b1, 32'h0,   -1, 0, 1'b0, 0, 1'b0, 88,   0};

    do_reset();
    #1;
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_return", ap_return, 0);
    check("rst_fail_valid", fail_valid, 0);
    check("rst_vec_ce", vec_ce, 0);
    check("rst_core_start", core_start, 0);
    check("rst_timeout", timeout_flag, 0);

    for (int t = 0; t < 5; t++) begin
      setup(tbl[t]);
      do_reset();
      run(n, cs);
      check({tbl[t].name, "_cycles"}, n, tbl[t].exp_cycles);
      check({tbl[t].name, "_ready"}, ap_ready, 1);
      check({tbl[t].name, "_return"}, ap_return, tbl[t].exp_ret);
      check({tbl[t].name, "_fail_valid"}, fail_valid, tbl[t].exp_fv);
      check({tbl[t].name, "_first_idx"}, first_fail_idx, tbl[t].exp_first);
      check({tbl[t].name, "_timeout"}, timeout_flag, tbl[t].exp_tmo);
      check({tbl[t].name, "_core_start_cycles"}, cs, tbl[t].exp_cs);
      held = ap_return;
      repeat (3) @(posedge ap_clk);
      #1;
      check({tbl[t].name, "_return_held"}, ap_return, held);
      check({tbl[t].name, "_idle_after"}, ap_idle, 1);
    end

    // Reset while the core call is outstanding.
    setup(tbl[0]);
    do_reset();
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    n = 0;
    while (!core_start && n < 50) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    check("midwait_call_seen", core_start, 1);
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    check("midwait_core_start", core_start, 0);
    check("midwait_idle", ap_idle, 1);
    check("midwait_vec_ce", vec_ce, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("midwait_idle_after_release", ap_idle, 1);

    // Key bit 0 must perturb count or timing relative to the golden run.
    setup(tbl[0]);
    working_key = 64'h1;
    do_reset();
    run(n, cs);
    check("key1_differs", ((n != 176) || (ap_return != 0)) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_vector_checker.md
FP_VECTOR_CHECKER -- requirements
Module: fp_vector_checker

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 64, vector/result width.
- DEPTH, 22, number of test vectors.
- ADDR_W, 5, vector address width; DEPTH <= 2^ADDR_W.
- CNT_W, 8, mismatch-counter width.
- TMO_W, 10, per-vector core timeout counter width.
- KEY_W, 64, working_key width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- ap_clk, in, 1, sole clock.
- ap_rst_n, in, 1, asynchronous active-low reset.
- ap_start, in, 1, run request.
- ap_done, out, 1, run complete pulse.
- ap_idle, out, 1, idle flag.
- ap_ready, out, 1, accept pulse.
- stop_on_fail, in, 1, abort the run on the first mismatch; sampled at start.
- vec_ce, out, 1, vector read enable.
- vec_addr, out, ADDR_W, vector index.
- vec_a, in, DATA_W, operand A; read data valid 1 cycle after vec_ce.
- vec_b, in, DATA_W, operand B; same timing as vec_a.
- vec_z, in, DATA_W, expected result; same timing as vec_a.
- core_start, out, 1, subtract-core start.
- core_a, out, DATA_W, operand A to core.
- core_b, out, DATA_W, operand B to core.
- core_zsign, out, 1, sign of A to core.
- core_done, in, 1, core done.
- core_result, in, DATA_W, core result; valid while core_done=1.
- ap_return, out, CNT_W, mismatch count.
- fail_valid, out, 1, at least one mismatch recorded.
- first_fail_idx, out, ADDR_W, index of the first mismatch.
- timeout_flag, out, 1, a core call timed out.
- working_key, in, KEY_W, locking key.

Function
REQ-003 States SHALL be IDLE, FETCH, LOAD, CALL, WAIT, CHECK, held in a one-hot register.
REQ-004 IDLE: ap_idle=1 when ap_start=0; when ap_start=1, the block SHALL clear idx, count, fail_valid, first_fail_idx and timeout_flag, latch stop_on_fail, and go to FETCH.
REQ-005 FETCH: if idx==DEPTH, or an abort is pending, the block SHALL pulse ap_done=ap_ready=1 for 1 cycle and go to IDLE; otherwise it SHALL assert vec_ce with vec_addr=idx and go to LOAD.
REQ-006 LOAD: the block SHALL register vec_a, vec_b and vec_z, and set core_zsign=vec_a[DATA_W-1].
- If vec_a[DATA_W-1] XOR vec_b[DATA_W-1] is 1, next state SHALL be CALL.
- Otherwise the vector is skipped (counted as pass) and next state SHALL be CHECK with no compare.
REQ-007 CALL: core_start SHALL rise and stay high until the first cycle in which core_done=1; the timeout counter is cleared; next state SHALL be WAIT.
REQ-008 WAIT: the block SHALL stay until core_done=1, then capture core_result and go to CHECK.
- If the timeout counter reaches 2^TMO_W-1 first, the block SHALL set timeout_flag, treat the vector as a mismatch, deassert core_start, and go to CHECK.
REQ-009 CHECK: for a non-skipped vector, if result != expected, the block SHALL saturating-increment count (stops at 2^CNT_W-1).
- On the first mismatch it SHALL set fail_valid and record idx into first_fail_idx.
- It SHALL always increment idx and go to FETCH.
- If stop_on_fail is latched and a mismatch occurred, an abort SHALL be pending.
REQ-010 Every vector SHALL cost 4 cycles when skipped, and 5 + core latency cycles when called.
REQ-011 ap_return SHALL equal the registered count at all times; it is held after done until the next start.
REQ-012 ap_start asserted outside IDLE SHALL be ignored.
REQ-013 core_done asserted outside WAIT/CALL SHALL be ignored.
REQ-014 Locking: working_key[3:0] SHALL be 4'b0000 for correct operation. Each set bit SHALL redirect one transition:
- k0: IDLE->LOAD.
- k1: FETCH end->CHECK.
- k2: skip path LOAD->FETCH.
- k3: WAIT->FETCH.
Bits above 3 SHALL be unused.

Reset
REQ-015 ap_rst_n=0 SHALL asynchronously force state IDLE, core_start=0, vec_ce=0, idx=0, count=0, fail_valid=0, first_fail_idx=0, timeout_flag=0, ap_done=0 and ap_ready=0.
REQ-016 Reset during WAIT SHALL abandon the core call; the first edge after release SHALL see state IDLE.

Structure
REQ-017 A shared package SHALL hold the state encoding and the default parameter values.
REQ-018 The compare/saturating-counter/first-fail logic SHALL be one sub-module, fp_mismatch_tracker.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- DEPTH=22, all signs differ, core returns vec_z after 3 cycles, key=0 -> ap_done after 22x8 cycles, ap_return=0, fail_valid=0.
- Core corrupts vectors 5 and 9 -> ap_return=2, first_fail_idx=5.
- Same as above with stop_on_fail=1 -> ap_done after vector 5, ap_return=1.
- Vector 3 core_done never rises -> timeout_flag=1, ap_return=1, run completes.
- All signs equal -> no core_start, ap_return=0, 88 cycles.
- ap_rst_n low mid-WAIT -> core_start=0 and ap_idle=1 immediately.
- Key=4'b0001 -> differs from golden count or timing.
